// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
// DIV_LATENCY counts cycles from the accept edge to the done pulse and is used to size stalls.
package mips_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN,
      DONE
   } div_state_e;

   localparam int unsigned DIV_WIDTH   = 32;
   localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder
// and subtract the divisor. The borrow out of the WIDTH+1-bit difference selects restore.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o,
   output logic             borrow_o
);

   logic [WIDTH:0] trial;

   always_comb begin
      trial    = {rem_i, quo_i[WIDTH-1]} - {1'b0, dvs_i};
      borrow_o = trial[WIDTH];
      // Restored value drops the shifted-out MSB: when it is set no borrow can occur.
      rem_o    = borrow_o ? {rem_i[WIDTH-2:0], quo_i[WIDTH-1]} : trial[WIDTH-1:0];
      quo_o    = {quo_i[WIDTH-2:0], ~borrow_o};
   end

endmodule

// File: rtl/mips_iter_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient feeds LO, remainder feeds HI.
// Fixed latency regardless of operands; divide-by-zero returns all-ones / raw dividend.
module mips_iter_divider
   import mips_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dz_out_q, dz_out_d;

   logic [WIDTH-1:0] step_rem, step_quo;
   logic             step_borrow;
   logic             accept;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_i    (rem_q),
      .quo_i    (quo_q),
      .dvs_i    (dvs_q),
      .rem_o    (step_rem),
      .quo_o    (step_quo),
      .borrow_o (step_borrow)
   );

   assign accept = start & ((state_q == IDLE) | (state_q == DONE));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      dvd_raw_d   = dvd_raw_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_out_d    = dz_out_q;

      unique case (state_q)
         IDLE: ;
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = SIGN;
         end
         SIGN: begin
            if (dz_q) begin
               quotient_d  = '1;
               remainder_d = dvd_raw_q;
               dz_out_d    = 1'b1;
            end else begin
               quotient_d  = q_neg_q ? -quo_q : quo_q;
               remainder_d = r_neg_q ? -rem_q : rem_q;
               dz_out_d    = 1'b0;
            end
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The quotient register starts out holding |dividend| and shifts it out MSB-first.
      if (accept) begin
         quo_d     = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
         dvs_d     = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
         dvd_raw_d = dividend;
         q_neg_d   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         r_neg_d   = is_signed & dividend[WIDTH-1];
         dz_d      = (divisor == '0);
         rem_d     = '0;
         cnt_d     = CNT_W'(WIDTH);
         state_d   = CALC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dvd_raw_q   <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_out_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         dvd_raw_q   <= dvd_raw_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dz_out_q    <= dz_out_d;
      end
   end

   assign busy        = (state_q == CALC) | (state_q == SIGN);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_mips_iter_divider.sv
// Self-checking bench for mips_iter_divider: table vectors, random ops against a reference
// model, and hand-written sequences for ignored start, back-to-back and mid-operation reset.
module tb_mips_iter_divider;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   mips_iter_divider #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   typedef struct {
      string        name;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int unsigned  cyc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned busy_run = 0;
   int unsigned done_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (sgn) begin
         q  = W'(sa / sb);
         r  = W'(sa % sb);
         dz = 1'b0;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endfunction

   // Caller is aligned on a negedge; the request is accepted at the next posedge.
   task automatic drive_op(input string name, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic dz);
      exp_t e;
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      e.name = name;
      e.q    = q;
      e.r    = r;
      e.dz   = dz;
      e.cyc  = cyc + 1 + W + 1;
      sb_q.push_back(e);
      @(negedge clk);
      start     = 1'b0;
      is_signed = 1'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", 32'd1, 32'd0);
         sb_q.delete();
      end
   endtask

   // Scoreboard monitor: every done pulse pops and checks one expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_run = 0;
         end else begin
            if (busy) busy_run++;
            if (done) begin
               done_seen++;
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check({e.name, "_quotient"}, quotient, e.q);
                  check({e.name, "_remainder"}, remainder, e.r);
                  check({e.name, "_dz"}, 32'(div_by_zero), 32'(e.dz));
                  check({e.name, "_latency"}, cyc, e.cyc);
                  check({e.name, "_busy_cycles"}, busy_run, W + 1);
               end
               busy_run = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   vec_t         vecs[10];
   logic [W-1:0] mq, mr;
   logic         mdz;
   logic [W-1:0] ra, rb;
   int unsigned  seen0;

   initial begin
      vecs[0] = '{"divu_100_7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
      vecs[1] = '{"div_m7_2",        1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
      vecs[2] = '{"div_7_m2",        1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
      vecs[3] = '{"div_overflow",    1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
      vecs[4] = '{"divu_max_1",      1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
      vecs[5] = '{"div_by_zero_s",   1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1};
      vecs[6] = '{"divu_by_zero",    1'b0, 32'd12345,     32'd0,         32'hFFFFFFFF,  32'd12345,     1'b1};
      vecs[7] = '{"divu_max_16",     1'b0, 32'hFFFFFFFF,  32'd16,        32'h0FFFFFFF,  32'd15,        1'b0};
      vecs[8] = '{"div_m100_m7",     1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
      vecs[9] = '{"divu_5_9",        1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};

      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      check("reset_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].dz);
         wait_drain(60);
      end

      // Results must hold while idle.
      repeat (3) @(negedge clk);
      check("hold_quotient", quotient, 32'd0);
      check("hold_remainder", remainder, 32'd5);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         model(1'(i % 2), ra, rb, mq, mr, mdz);
         @(negedge clk);
         drive_op("random", 1'(i % 2), ra, rb, mq, mr, mdz);
         wait_drain(60);
      end

      // start pulsed during CALC with other operands must be ignored.
      @(negedge clk);
      drive_op("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (4) @(negedge clk);
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_drain(60);

      // Back-to-back: start presented in DONE is accepted directly.
      @(negedge clk);
      drive_op("b2b_first", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      begin
         int n = 0;
         while (!done && n < 60) begin
            @(negedge clk);
            n++;
         end
      end
      check("b2b_done_seen", 32'(done), 32'd1);
      drive_op("b2b_second", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      wait_drain(60);

      // Asynchronous reset mid-CALC aborts with no done pulse.
      @(negedge clk);
      drive_op("aborted", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
      repeat (8) @(negedge clk);
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      check("abort_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      seen0 = done_seen;
      repeat (40) @(negedge clk);
      check("abort_no_done", done_seen, seen0);
      drive_op("after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      wait_drain(60);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_iter_divider.md
Name: mips_iter_divider

Overview:
- Multi-cycle restoring divider for MIPS DIV/DIVU. Produces quotient (LO) and remainder (HI) through a rippled subtract/borrow chain, one quotient bit per cycle.
- Sits beside the ALU/carry-lookahead adder path in the execute stage. Control stalls on busy and writes HI/LO on done.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE or DONE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  numerator (rs). Captured when start is accepted.
- divisor  input  WIDTH  denominator (rt). Captured when start is accepted.
- busy  output  1  high in CALC and SIGN.
- done  output  1  one-cycle pulse, high in DONE.
- quotient  output  WIDTH  result for LO. Registered.
- remainder  output  WIDTH  result for HI. Registered.
- div_by_zero  output  1  registered flag, valid with done.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0; busy, done, div_by_zero, quotient, remainder all 0.
- Mid-operation reset: abort with no done pulse; next start behaves as a fresh request.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start=1 at edge T:
  - capture |dividend| and |divisor| (magnitude only when is_signed=1 and MSB=1; else raw);
  - capture q_neg = is_signed & (dividend[MSB]^divisor[MSB]), r_neg = is_signed & dividend[MSB], and dz = (divisor==0);
  - clear the partial remainder; counter=WIDTH; go to CALC.
- CALC, each cycle:
  - trial = {rem[WIDTH-1:0], quo[MSB]} - {1'b0, dvs}, computed at WIDTH+1 bits;
  - borrow=0: rem=trial, shift in quotient bit 1; borrow=1: rem = shifted value, shift in 0;
  - counter decrements; after WIDTH cycles go to SIGN.
- SIGN, one cycle:
  - dz=1: quotient=all ones, remainder=raw captured dividend, div_by_zero=1. No sign fix.
  - else: quotient = q_neg ? -q : q; remainder = r_neg ? -r : r. Truncating division: remainder takes the dividend's sign.
  - go to DONE.
- DONE, one cycle: done=1, busy=0. If start=1, accept as in IDLE (back-to-back) and go to CALC; else go to IDLE.
- Latency: start accepted at edge T; busy high T+1..T+WIDTH+1; done high in cycle T+WIDTH+2. Fixed, independent of operands and dz.
- start while busy: ignored, no effect.
- Results and div_by_zero hold from DONE until the SIGN cycle of the next operation, where they are overwritten.
- Overflow -2^(W-1) / -1 (signed): quotient=0x80000000, remainder=0. This is the natural wrap; no flag is raised.
- Operands may change after the accept edge without effect.
- Arithmetic: all negation is two's complement, modulo 2^WIDTH. Borrow is the MSB of the WIDTH+1-bit trial difference.

Decomposition:
- Shared package mips_div_pkg holds the state enum (IDLE/CALC/SIGN/DONE), the DIV_WIDTH=32 constant, and the DIV_LATENCY=WIDTH+2 constant that control uses for stall sizing.
- Sub-module div_step: combinational, one restoring iteration. Inputs rem, quo, dvs. Outputs next rem, next quo, borrow.
- Top holds the FSM, counter, and sign capture/fix.

Test Plan:
- DIVU 100/7: start at T -> done at T+34; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 33 cycles.
- DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7/-2 -> quotient=-3, remainder=1.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero, DIV 0xFFFFFFF9/0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFF9, div_by_zero=1, same 34-cycle latency.
- start pulsed during CALC with different operands -> ignored, original result delivered. start held high in DONE -> second op accepted, its done exactly 34 cycles after the first done.
- rst asserted mid-CALC (cycle 10), asynchronously between edges -> busy, done, quotient, remainder fall to 0 immediately; no done pulse; a subsequent 100/7 yields 14/2.
